alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit arithmetic/logic unit built as a ripple chain of 32 identical 1-bit ALU slices, in the classic MIPS-style datapath form.
- Performs AND, OR, ADD/SUB (via Binvert and Carryin) and set-less-than.
- Outputs are registered, giving one cycle of latency.
- Sits in the execute stage, driven by the ALU control decoder.

Parameters:
- WIDTH, 32, operand/result width in bits. The ripple chain has WIDTH slices.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- Binvert  input  1  when 1, each slice uses ~b[i] in place of b[i] for all operations.
- Carryin  input  1  carry into bit 0 of the adder chain.
- Operation  input  2  00 AND, 01 OR, 10 ADD, 11 SLT.
- Result  output  WIDTH  registered result.
- CarryOut  output  1  registered carry out of bit WIDTH-1 of the adder.

Behaviour:
- Operand select: bb = Binvert ? ~b : b. bb feeds every operation, so AND/OR with Binvert=1 compute a&~b and a|~b.
- Adder chain:
  - sum = a + bb + Carryin, ripple through the slices.
  - c0 = Carryin; c[i+1] = carry out of slice i.
  - The adder is always evaluated, independent of Operation.
- Operation decode:
  - 00: R = a & bb.
  - 01: R = a | bb.
  - 10: R = sum[WIDTH-1:0].
  - 11 (SLT): R = {WIDTH-1 zeros, set}.
    - set = sum[WIDTH-1] XOR ovf, where ovf = c[WIDTH] XOR c[WIDTH-1] (signed overflow corrected).
    - Meaningful as signed a<b when Binvert=1 and Carryin=1. No special handling otherwise; the formula applies as written.
- CarryOut:
  - Always equals c[WIDTH] of the current adder evaluation, for every Operation value.
  - Subtraction a−b requires Binvert=1 and Carryin=1. Binvert=1 with Carryin=0 yields a+~b = a−b−1; this is legal and not flagged.
  - Unsigned a>=b ⇔ CarryOut=1 on a full subtract.
- Timing:
  - On each rising clk edge with rst=0: Result<=R, CarryOut<=c[WIDTH].
  - Latency is exactly 1 cycle from input change to registered output.
  - New inputs are accepted every cycle. There is no handshake.
- Reset:
  - On a rising edge with rst=1: Result<=0, CarryOut<=0, regardless of inputs.
  - Reset held across multiple cycles keeps outputs at 0.
  - The first non-reset edge loads the current combinational value.
- No other state. X/Z on inputs propagate; no masking.

Test Plan:
- Reset: drive rst=1 for 2 cycles with a=FFFFFFFF, b=1, Operation=10 -> Result=0, CarryOut=0. Deassert -> next edge Result=0, CarryOut=1.
- Logic ops, with a=A5A5A5A5, b=5A5A5A5A, Binvert=0, Carryin=0:
  - Operation=00 -> Result=00000000.
  - Operation=01 -> Result=FFFFFFFF.
  - Each appears one cycle after the input change.
- Add: same operands, Operation=10, Binvert=0, Carryin=0 -> Result=FFFFFFFF, CarryOut=0. Also a=FFFFFFFF, b=1 -> Result=0, CarryOut=1.
- Inverted b, same a and b:
  - Binvert=1, Carryin=0, Operation=10 -> Result=4B4B4B4A, CarryOut=1.
  - Carryin=1 -> Result=4B4B4B4B, CarryOut=1.
  - Operation=00 with Binvert=1 -> Result=A5A5A5A5.
- SLT, Binvert=1, Carryin=1, Operation=11:
  - a=1, b=2 -> Result=1.
  - a=2, b=1 -> Result=0.
  - a=80000000, b=1 (overflow case) -> Result=1.
  - a=7FFFFFFF, b=FFFFFFFF -> Result=0.
- Back-to-back: change Operation every cycle through 00,01,10,11 -> each Result matches the prior cycle's inputs with no bubbles. Asserting rst mid-sequence zeroes outputs on that edge.

Source files
------------

// File: rtl/alu.sv
// 32-bit MIPS-style ALU: a ripple chain of WIDTH identical 1-bit slices
// performing AND, OR, ADD/SUB and signed set-less-than. Result and CarryOut
// are registered, giving one cycle of latency with a new operation accepted
// every cycle (no handshake).
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Binvert,
  input  logic             Carryin,
  input  logic [1:0]       Operation,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  // One 1-bit ALU slice. Returns {cout, sum, res}. The 'less' input is what
  // the slice drives onto its result for SLT; only bit 0 ever sees a nonzero
  // value (the corrected sign from the MSB slice).
  function automatic logic [2:0] alu_slice(
    input logic       ai,
    input logic       bi,
    input logic       binv,
    input logic       cin,
    input logic       less,
    input logic [1:0] op
  );
    logic bb;
    logic s;
    logic co;
    logic r;
    bb = binv ? ~bi : bi;
    s  = ai ^ bb ^ cin;
    co = (ai & bb) | (ai & cin) | (bb & cin);
    unique case (op)
      OP_AND:  r = ai & bb;
      OP_OR:   r = ai | bb;
      OP_ADD:  r = s;
      OP_SLT:  r = less;
      default: r = 1'bx;
    endcase
    return {co, s, r};
  endfunction

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] r_comb;
  logic             ovf;
  logic             set_bit;
  logic [2:0]       slice_out;
  logic [2:0]       slice0_out;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;

  // Ripple the carry through the slice chain; the adder is always evaluated,
  // so CarryOut is meaningful for every Operation value.
  always_comb begin
    carry      = '0;
    sum        = '0;
    r_comb     = '0;
    slice_out  = '0;
    slice0_out = '0;
    carry[0]   = Carryin;
    for (int i = 0; i < WIDTH; i++) begin
      slice_out    = alu_slice(a[i], b[i], Binvert, carry[i], 1'b0, Operation);
      carry[i+1]   = slice_out[2];
      sum[i]       = slice_out[1];
      r_comb[i]    = slice_out[0];
    end
    // Signed-overflow-corrected sign of a + bb + Carryin feeds back to bit 0.
    ovf        = carry[WIDTH] ^ carry[WIDTH-1];
    set_bit    = sum[WIDTH-1] ^ ovf;
    slice0_out = alu_slice(a[0], b[0], Binvert, carry[0], set_bit, Operation);
    r_comb[0]  = slice0_out[0];
  end

  // Next-state for the output registers; reset wins over any input.
  always_comb begin
    result_d = r_comb;
    carry_d  = carry[WIDTH];
    if (rst) begin
      result_d = '0;
      carry_d  = 1'b0;
    end
  end

  // Output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    result_q <= result_d;
    carry_q  <= carry_d;
  end

  assign Result   = result_q;
  assign CarryOut = carry_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: each step drives one input vector, confirms the
// registered outputs still hold the previous result before the edge, then
// checks the hand-computed result one cycle later.
module tb_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         Binvert;
  logic         Carryin;
  logic [1:0]   Operation;
  logic [W-1:0] Result;
  logic         CarryOut;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] prev_r;
  logic         prev_c;

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .Binvert   (Binvert),
    .Carryin   (Carryin),
    .Operation (Operation),
    .Result    (Result),
    .CarryOut  (CarryOut)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp_r, input logic exp_c);
    checks++;
    assert (Result === exp_r) else begin
      errors++;
      $error("FAIL %s Result got %h expected %h", tag, Result, exp_r);
    end
    checks++;
    assert (CarryOut === exp_c) else begin
      errors++;
      $error("FAIL %s CarryOut got %b expected %b", tag, CarryOut, exp_c);
    end
  endtask

  // Drive one vector just after an edge, verify outputs hold until the next
  // edge, then verify the new registered values after it.
  task automatic step(input string tag, input logic r, input logic [1:0] op,
                      input logic binv, input logic cin,
                      input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] exp_r, input logic exp_c);
    rst       = r;
    Operation = op;
    Binvert   = binv;
    Carryin   = cin;
    a         = va;
    b         = vb;
    #2;
    check({tag, "_hold"}, prev_r, prev_c);
    @(posedge clk);
    #1;
    check(tag, exp_r, exp_c);
    prev_r = exp_r;
    prev_c = exp_c;
  endtask

  initial begin
    rst       = 1'b1;
    a         = 32'hFFFF_FFFF;
    b         = 32'h0000_0001;
    Binvert   = 1'b0;
    Carryin   = 1'b0;
    Operation = 2'b10;

    // Reset held for two edges with an add that would carry out.
    @(posedge clk); #1;
    check("rst1", 32'h0, 1'b0);
    @(posedge clk); #1;
    check("rst2", 32'h0, 1'b0);
    prev_r = 32'h0;
    prev_c = 1'b0;

    // First non-reset edge loads FFFFFFFF + 1.
    step("rst_release", 1'b0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);

    // Logic operations
    step("and",  1'b0, 2'b00, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0000, 1'b0);
    step("or",   1'b0, 2'b01, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0);

    // Addition
    step("add",       1'b0, 2'b10, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0);
    step("add_carry", 1'b0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    // CarryOut reflects the adder even during a logic op.
    step("and_carry", 1'b0, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1);

    // Inverted b
    step("add_binv",     1'b0, 2'b10, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h4B4B_4B4A, 1'b1);
    step("sub",          1'b0, 2'b10, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h4B4B_4B4B, 1'b1);
    step("and_binv",     1'b0, 2'b00, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 1'b1);
    step("or_binv",      1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_00F0, 32'hFFFF_FF0F, 32'h0000_00F0, 1'b0);

    // Set-less-than (signed)
    step("slt_1_2",      1'b0, 2'b11, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0);
    step("slt_2_1",      1'b0, 2'b11, 1'b1, 1'b1, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b1);
    step("slt_ovf_neg",  1'b0, 2'b11, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b1);
    step("slt_ovf_pos",  1'b0, 2'b11, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    // Back-to-back operation changes, no bubbles
    step("b2b_and", 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0005, 32'h0000_0004, 1'b0);
    step("b2b_or",  1'b0, 2'b01, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0005, 32'h0000_000D, 1'b0);
    step("b2b_add", 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0005, 32'h0000_0011, 1'b0);
    step("b2b_slt", 1'b0, 2'b11, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0005, 32'h0000_0000, 1'b0);
    step("b2b_slt2",1'b0, 2'b11, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_000C, 32'h0000_0001, 1'b0);

    // Reset asserted mid-sequence, then resume
    step("mid_rst",   1'b1, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    step("post_rst",  1'b0, 2'b01, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0);
    step("post_rst2", 1'b0, 2'b10, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
